hdmi_rd_sched: RTL and testbench

Read-command scheduler for the HDMI output path. It sits between the video timing generator and the DDR read port, and issues burst read commands that prefetch each active line into the pixel FIFO ahead of display. It also selects which of two frame buffers is read, and latches the read mode, only at frame start. It reports underruns when display data is requested before its line has been fetched.

---
 rtl/hdmi_rd_sched.sv | 143 ++++++++++++++
 tb/tb_hdmi_rd_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rd_sched.sv
// Burst read-command scheduler: prefetches active lines into the pixel FIFO, frame-buffer/mode latched at frame start.
// Frame start one cycle after the synchronised vs edge; a command holds valid/addr/len until rd_cmd_ready, then one FILL cycle.
module hdmi_rd_sched #(
  parameter int ADDR_BITS = 28,
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int BURST_LEN = 256,
  parameter int PREFETCH_LINES = 2,
  parameter int LINE_STRIDE = 4096,
  parameter logic [ADDR_BITS-1:0] FB_BASE0 = 28'h000_0000,
  parameter logic [ADDR_BITS-1:0] FB_BASE1 = 28'h080_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vs_in,
  input  logic                 de_in,
  input  logic [1:0]           rd_mode,
  input  logic                 wr_done,
  input  logic                 wr_buf,
  input  logic [11:0]          fifo_space,
  output logic                 rd_cmd_valid,
  input  logic                 rd_cmd_ready,
  output logic [ADDR_BITS-1:0] rd_cmd_addr,
  output logic [8:0]           rd_cmd_len,
  output logic                 rd_buf,
  output logic [1:0]           rd_mode_lat,
  output logic                 frame_active,
  output logic                 underrun
);

  localparam int NB = (H_ACT + BURST_LEN - 1) / BURST_LEN;
  localparam int LW = $clog2(V_ACT + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = $clog2(PREFETCH_LINES + 1);
  localparam logic [8:0] LEN_FULL = 9'(BURST_LEN);
  localparam logic [8:0] LEN_LAST = 9'(H_ACT - (NB - 1) * BURST_LEN);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;

  state_t          state, state_nxt;
  logic            vs_q, vs_d, de_q, de_d;
  logic            last_done, new_flag, abort_pend;
  logic [LW-1:0]   line;
  logic [BW-1:0]   burst;
  logic [PW-1:0]   lines_ahead;
  logic            vs_rise, de_rise, de_fall;
  logic            accept, last_burst, start;
  logic [8:0]      cur_len;
  logic [ADDR_BITS-1:0] addr_calc;

  assign vs_rise    = vs_q & ~vs_d;
  assign de_rise    = de_q & ~de_d;
  assign de_fall    = ~de_q & de_d;
  assign last_burst = (burst == BW'(NB - 1));
  assign cur_len    = last_burst ? LEN_LAST : LEN_FULL;
  assign accept     = (state == ISSUE) && rd_cmd_ready;

  // Modular arithmetic: truncating each term to ADDR_BITS gives the same low bits as the full sum.
  assign addr_calc = (rd_buf ? FB_BASE1 : FB_BASE0)
                   + ADDR_BITS'(line)  * ADDR_BITS'(LINE_STRIDE)
                   + ADDR_BITS'(burst) * ADDR_BITS'(BURST_LEN * 2);

  assign rd_cmd_valid = (state == ISSUE);
  assign rd_cmd_addr  = rd_cmd_valid ? addr_calc : '0;
  assign rd_cmd_len   = rd_cmd_valid ? cur_len : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE, DONE: if (vs_rise) start = 1'b1;
      FILL: begin
        if (vs_rise) start = 1'b1;
        else if (lines_ahead < PW'(PREFETCH_LINES) && fifo_space >= {3'b000, cur_len})
          state_nxt = ISSUE;
      end
      ISSUE: begin
        // An abort waits for the in-flight command so valid never drops without an accept.
        if (accept) begin
          if (abort_pend || vs_rise)                    start = 1'b1;
          else if (last_burst && line == LW'(V_ACT - 1)) state_nxt = DONE;
          else                                          state_nxt = FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0; vs_d <= 1'b0; de_q <= 1'b0; de_d <= 1'b0;
      last_done <= 1'b0; new_flag <= 1'b0; abort_pend <= 1'b0;
      rd_buf <= 1'b0; rd_mode_lat <= 2'b00; frame_active <= 1'b0; underrun <= 1'b0;
      line <= '0; burst <= '0; lines_ahead <= '0;
    end else begin
      vs_q <= vs_in; vs_d <= vs_q;
      de_q <= de_in; de_d <= de_q;
      underrun <= de_rise && (lines_ahead == '0);
      if (wr_done) begin
        last_done <= wr_buf;
        new_flag  <= 1'b1;
      end
      if (start) begin
        // A completion arriving on the frame-start cycle is used immediately.
        if (wr_done) begin
          rd_buf   <= wr_buf;
          new_flag <= 1'b0;
        end else if (new_flag) begin
          rd_buf   <= last_done;
          new_flag <= 1'b0;
        end
        rd_mode_lat  <= rd_mode;
        line         <= '0;
        burst        <= '0;
        lines_ahead  <= '0;
        frame_active <= 1'b1;
        abort_pend   <= 1'b0;
      end else begin
        if (state == ISSUE && vs_rise) abort_pend <= 1'b1;
        if (accept) begin
          if (last_burst) begin
            burst <= '0;
            line  <= line + 1'b1;
          end else begin
            burst <= burst + 1'b1;
          end
        end
        if (accept && last_burst && !de_fall)
          lines_ahead <= lines_ahead + 1'b1;
        else if (!(accept && last_burst) && de_fall && lines_ahead != '0)
          lines_ahead <= lines_ahead - 1'b1;
        if (state == ISSUE && state_nxt == DONE) frame_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_rd_sched.sv
// Directed bench for hdmi_rd_sched: command-sequence model plus literal checkpoints.
module tb_hdmi_rd_sched;

  localparam int H = 1920;
  localparam int BL = 256;
  localparam int NB = (H + BL - 1) / BL;
  localparam int LAST = H - (NB - 1) * BL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vs_in, de_in, wr_done, wr_buf, rd_cmd_ready;
  logic [1:0]  rd_mode;
  logic [11:0] fifo_space;
  logic        rd_cmd_valid, rd_buf, frame_active, underrun;
  logic [27:0] rd_cmd_addr;
  logic [8:0]  rd_cmd_len;
  logic [1:0]  rd_mode_lat;

  logic        s_rst, s_vs, s_de, s_ready;
  logic        s_valid, s_buf, s_fa, s_under;
  logic [27:0] s_addr;
  logic [8:0]  s_len;
  logic [1:0]  s_mode;

  hdmi_rd_sched u_dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rd_mode(rd_mode),
    .wr_done(wr_done), .wr_buf(wr_buf), .fifo_space(fifo_space),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_buf(rd_buf),
    .rd_mode_lat(rd_mode_lat), .frame_active(frame_active), .underrun(underrun)
  );

  hdmi_rd_sched #(.V_ACT(4), .PREFETCH_LINES(2)) u_small (
    .clk(clk), .rst(s_rst), .vs_in(s_vs), .de_in(s_de), .rd_mode(2'b00),
    .wr_done(1'b0), .wr_buf(1'b0), .fifo_space(12'd4095),
    .rd_cmd_valid(s_valid), .rd_cmd_ready(s_ready),
    .rd_cmd_addr(s_addr), .rd_cmd_len(s_len), .rd_buf(s_buf),
    .rd_mode_lat(s_mode), .frame_active(s_fa), .underrun(s_under)
  );

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int s_acc = 0;
  int ucount;
  int m_k = 0;
  bit m_pend = 1'b0;
  bit chk_en = 1'b0;
  bit s_fa_chk = 1'b0;
  logic [27:0] m_base = 28'h0;
  logic [27:0] addr_log[$];
  logic [8:0]  len_log[$];

  bit          pv = 1'b0;
  bit          pacc = 1'b0;
  logic [27:0] paddr;
  logic [8:0]  plen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] exp_addr(input int k);
    return m_base + 28'((k / NB) * 4096) + 28'((k % NB) * BL * 2);
  endfunction

  function automatic logic [8:0] exp_len(input int k);
    return ((k % NB) == NB - 1) ? 9'(LAST) : 9'(BL);
  endfunction

  function automatic logic [31:0] log_addr(input int i);
    return (i < addr_log.size()) ? {4'h0, addr_log[i]} : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] log_len(input int i);
    return (i < len_log.size()) ? {23'h0, len_log[i]} : 32'hxxxxxxxx;
  endfunction

  // Every cycle: issued command matches the model, and a stalled command holds steady.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else if (chk_en) begin
      if (rd_cmd_valid) begin
        check("cmd_addr", {4'h0, rd_cmd_addr}, {4'h0, exp_addr(m_k)});
        check("cmd_len", {23'h0, rd_cmd_len}, {23'h0, exp_len(m_k)});
      end
      if (pv && !pacc) begin
        check("hold_valid", {31'h0, rd_cmd_valid}, 32'd1);
        check("hold_addr", {4'h0, rd_cmd_addr}, {4'h0, paddr});
        check("hold_len", {23'h0, rd_cmd_len}, {23'h0, plen});
      end
      pacc = rd_cmd_valid && rd_cmd_ready;
      pv = rd_cmd_valid;
      paddr = rd_cmd_addr;
      plen = rd_cmd_len;
      if (pacc) begin
        n_acc++;
        addr_log.push_back(rd_cmd_addr);
        len_log.push_back(rd_cmd_len);
        if (m_pend) begin
          m_k = 0;
          m_pend = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!s_rst) begin
      if (s_fa_chk) begin
        check("small_fa_fall", {31'h0, s_fa}, 32'd0);
        s_fa_chk = 1'b0;
      end
      if (s_valid && s_ready) begin
        s_acc++;
        if (s_acc == 32) begin
          check("small_fa_before_last", {31'h0, s_fa}, 32'd1);
          s_fa_chk = 1'b1;
        end
      end
    end
  end

  task automatic clear_log();
    n_acc = 0;
    addr_log.delete();
    len_log.delete();
  endtask

  task automatic vs_pulse(input bit pend);
    if (pend) m_pend = 1'b1;
    else      m_k = 0;
    vs_in = 1'b1;
    @(posedge clk); #1;
    vs_in = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!rd_cmd_valid && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rd_cmd_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no valid within %0d cycles, required valid", lim);
    end
  endtask

  task automatic do_accept();
    wait_valid(20);
    rd_cmd_ready = 1'b1;
    @(posedge clk); #1;
    rd_cmd_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    vs_in = 1'b0; de_in = 1'b0; rd_mode = 2'b00; wr_done = 1'b0; wr_buf = 1'b0;
    fifo_space = 12'd0; rd_cmd_ready = 1'b0;
    s_vs = 1'b0; s_de = 1'b0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, rd_cmd_valid}, 32'd0);
    check("rst_addr", {4'h0, rd_cmd_addr}, 32'd0);
    check("rst_len", {23'h0, rd_cmd_len}, 32'd0);
    check("rst_buf", {31'h0, rd_buf}, 32'd0);
    check("rst_mode", {30'h0, rd_mode_lat}, 32'd0);
    check("rst_fa", {31'h0, frame_active}, 32'd0);
    check("rst_under", {31'h0, underrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_rst = 1'b0; chk_en = 1'b1;

    // Frame on buffer 0, nothing displayed: two lines prefetched then stall.
    fifo_space = 12'd4095; rd_cmd_ready = 1'b1; rd_mode = 2'b10;
    clear_log();
    vs_pulse(1'b0);
    repeat (60) @(posedge clk); #1;
    check("t1_count", n_acc, 32'd16);
    check("t1_first_addr", log_addr(0), 32'd0);
    check("t1_addr7", log_addr(7), 32'd3584);
    check("t1_len6", log_len(6), 32'd256);
    check("t1_len7", log_len(7), 32'd128);
    check("t1_addr8", log_addr(8), 32'd4096);
    check("t1_last_addr", log_addr(15), 32'd7680);
    check("t1_lines_ahead", {30'h0, u_dut.lines_ahead}, 32'd2);
    check("t1_stall_valid", {31'h0, rd_cmd_valid}, 32'd0);
    check("t1_mode", {30'h0, rd_mode_lat}, 32'd2);
    check("t1_fa", {31'h0, frame_active}, 32'd1);

    // Mode only latches at frame start; a completed buffer 1 is picked up at the next vs.
    rd_mode = 2'b01;
    wr_done = 1'b1; wr_buf = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0; wr_buf = 1'b0;
    check("t2_mode_midframe", {30'h0, rd_mode_lat}, 32'd2);
    check("t2_buf_midframe", {31'h0, rd_buf}, 32'd0);
    m_base = 28'h0800000;
    clear_log();
    vs_pulse(1'b0);
    repeat (60) @(posedge clk); #1;
    check("t2_buf", {31'h0, rd_buf}, 32'd1);
    check("t2_mode", {30'h0, rd_mode_lat}, 32'd1);
    check("t2_first_addr", log_addr(0), 32'h0800000);
    check("t2_count", n_acc, 32'd16);
    clear_log();
    vs_pulse(1'b0);
    repeat (60) @(posedge clk); #1;
    check("t2_repeat_buf", {31'h0, rd_buf}, 32'd1);
    check("t2_repeat_count", n_acc, 32'd16);

    // Backpressure: command held for 10 cycles, then exactly one accept.
    rd_cmd_ready = 1'b0;
    clear_log();
    vs_pulse(1'b0);
    wait_valid(10);
    repeat (10) @(posedge clk); #1;
    check("t3_valid_held", {31'h0, rd_cmd_valid}, 32'd1);
    check("t3_no_accept", n_acc, 32'd0);
    rd_cmd_ready = 1'b1;
    @(posedge clk); #1;
    rd_cmd_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t3_one_accept", n_acc, 32'd1);

    // Abort while a command is stalled: it completes, then the new frame restarts at line 0.
    wait_valid(10);
    clear_log();
    vs_pulse(1'b1);
    repeat (4) @(posedge clk); #1;
    check("t4_valid_kept", {31'h0, rd_cmd_valid}, 32'd1);
    check("t4_addr_kept", {4'h0, rd_cmd_addr}, 32'h0800200);
    rd_cmd_ready = 1'b1;
    repeat (60) @(posedge clk); #1;
    check("t4_count", n_acc, 32'd17);
    check("t4_pending_addr", log_addr(0), 32'h0800200);
    check("t4_restart_addr", log_addr(1), 32'h0800000);
    check("t4_last_addr", log_addr(16), 32'h0801E00);

    // Underrun: FIFO full so nothing is fetched, then display starts.
    fifo_space = 12'd0;
    clear_log();
    vs_pulse(1'b0);
    repeat (4) @(posedge clk); #1;
    de_in = 1'b1;
    ucount = 0;
    repeat (8) begin
      @(negedge clk);
      ucount += int'(underrun);
    end
    @(posedge clk); #1;
    check("t5_underrun_cycles", ucount, 32'd1);
    check("t5_no_cmds", n_acc, 32'd0);
    check("t5_lines_ahead", {30'h0, u_dut.lines_ahead}, 32'd0);

    // Line-completing accept coincident with a de falling edge leaves lines_ahead unchanged.
    rd_cmd_ready = 1'b0;
    fifo_space = 12'd4095;
    repeat (7) do_accept();
    wait_valid(10);
    check("t6_count7", n_acc, 32'd7);
    check("t6_last_len", {23'h0, rd_cmd_len}, 32'd128);
    de_in = 1'b0;
    @(posedge clk); #1;
    rd_cmd_ready = 1'b1;
    @(posedge clk); #1;
    rd_cmd_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_count8", n_acc, 32'd8);
    check("t6_lines_ahead", {30'h0, u_dut.lines_ahead}, 32'd0);

    // Reduced frame: four lines with display consuming each line.
    s_ready = 1'b1;
    s_vs = 1'b1;
    @(posedge clk); #1;
    s_vs = 1'b0;
    for (int c = 0; c < 400; c++) begin
      s_de = ((c % 16) >= 4) && ((c % 16) < 8);
      @(posedge clk); #1;
    end
    s_de = 1'b0;
    check("small_count", s_acc, 32'd32);
    check("small_fa_end", {31'h0, s_fa}, 32'd0);
    check("small_done_idle", {31'h0, s_valid}, 32'd0);

    // Reset during an in-flight command.
    s_ready = 1'b0;
    s_vs = 1'b1;
    @(posedge clk); #1;
    s_vs = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("small_inflight", {31'h0, s_valid}, 32'd1);
    s_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("small_rst_valid", {31'h0, s_valid}, 32'd0);
    check("small_rst_addr", {4'h0, s_addr}, 32'd0);
    check("small_rst_len", {23'h0, s_len}, 32'd0);
    check("small_rst_fa", {31'h0, s_fa}, 32'd0);
    check("small_rst_buf", {31'h0, s_buf}, 32'd0);
    check("small_rst_mode", {30'h0, s_mode}, 32'd0);
    check("small_rst_under", {31'h0, s_under}, 32'd0);
    @(posedge clk); #1;
    s_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
